perf_counter_ctrl: RTL and testbench

Controller for the pipeline's event-counter bank: branch predictions, mispredictions, retired instructions and similar per-instruction events. It owns NUM_EVENTS counters and accepts CLEAR, DUMP, FREEZE and UNFREEZE commands over a valid/ready port. On DUMP it snapshots every counter atomically and streams the snapshot out over a valid/ready port. It sits beside the IF/ID/EX pipeline, is fed by the commit/load strobe and per-event flags, and is read by the debug/testbench side.

---
 rtl/perf_counter_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_perf_counter_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: a bank of NUM_EVENTS event counters with a command port
// (CLEAR, DUMP, FREEZE, UNFREEZE) and a snapshot stream on a valid/ready port.
// A DUMP copies every counter into shadow registers in one cycle. The stream
// then reads only the shadow, so the live counters can keep counting.
// Optional macro PERF_CNT_SATURATE_EN: counters saturate instead of wrapping,
// and a sticky per-counter flag is streamed on out_sat.
module perf_counter_ctrl #(
    parameter int  NUM_EVENTS = 4,
    parameter int  CNT_WIDTH  = 32,
    localparam int IDX_WIDTH  = $clog2(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  event_valid,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    output logic                  cmd_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic [CNT_WIDTH-1:0]  out_data,
    output logic                  out_last,
`ifdef PERF_CNT_SATURATE_EN
    output logic                  out_sat,
`endif
    output logic                  frozen,
    output logic                  busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CMD_CLEAR    = 2'd0,
        CMD_DUMP     = 2'd1,
        CMD_FREEZE   = 2'd2,
        CMD_UNFREEZE = 2'd3
    } cmd_e;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_EVENTS - 1);
`ifdef PERF_CNT_SATURATE_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
`endif

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 frozen_q, frozen_d;
    logic [CNT_WIDTH-1:0] cnt_q    [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] cnt_d    [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS];
`ifdef PERF_CNT_SATURATE_EN
    logic [NUM_EVENTS-1:0] sat_q, sat_d, sat_shadow_q;
`endif

    cmd_e op;
    logic cmd_accept;
    logic do_clear;
    logic do_dump;
    logic count_en;

    // Command decode, stream FSM next state and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves a latch.
        op         = cmd_e'(cmd_op);
        state_d    = state_q;
        idx_d      = idx_q;
        frozen_d   = frozen_q;
        cmd_ready  = (state_q == S_IDLE);
        cmd_accept = cmd_valid && cmd_ready;
        do_clear   = cmd_accept && (op == CMD_CLEAR);
        do_dump    = cmd_accept && (op == CMD_DUMP);
        out_valid  = (state_q == S_STREAM);
        busy       = out_valid;
        out_last   = out_valid && (idx_q == LAST_IDX);

        if (cmd_accept && op == CMD_FREEZE) begin
            frozen_d = 1'b1;
        end else if (cmd_accept && op == CMD_UNFREEZE) begin
            frozen_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (do_dump) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter next values: frozen_q is the registered flag, so the FREEZE edge
    // still counts and the UNFREEZE edge does not. CLEAR overrides any event.
    always_comb begin
        count_en = event_valid && !frozen_q;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_d[i] = cnt_q[i];
`ifdef PERF_CNT_SATURATE_EN
            sat_d[i] = sat_q[i];
            if (count_en && event_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
            if (do_clear) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end
`else
            if (count_en && event_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
            if (do_clear) begin
                cnt_d[i] = '0;
            end
`endif
        end
    end

    // Control state register: FSM state, stream index, freeze flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its pre-edge inputs.
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            frozen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            frozen_q <= frozen_d;
        end
    end

    // Live counters and the DUMP snapshot. The snapshot takes cnt_d so that it
    // includes any increment made on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter and shadow arrays are reset because reset must
            // read back as all-zero counts and must zero the streamed data.
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
`ifdef PERF_CNT_SATURATE_EN
            sat_q        <= '0;
            sat_shadow_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (do_dump) begin
                    shadow_q[i] <= cnt_d[i];
                end
            end
`ifdef PERF_CNT_SATURATE_EN
            sat_q <= sat_d;
            if (do_dump) begin
                sat_shadow_q <= sat_d;
            end
`endif
        end
    end

    assign frozen   = frozen_q;
    assign out_idx  = idx_q;
    assign out_data = shadow_q[idx_q];
`ifdef PERF_CNT_SATURATE_EN
    assign out_sat  = sat_shadow_q[idx_q];
`endif

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Bench for perf_counter_ctrl. A queue-based model predicts the command and
// stream behaviour, and a compare process checks it on every falling edge.
// Directed sequences add literal expectations for each dump.
module tb_perf_counter_ctrl;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         event_valid = 1'b0;
    logic [N-1:0] event_vec = '0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'd0;
    logic         out_ready = 1'b0;
    logic         cmd_ready, out_valid, out_last, frozen, busy;
    logic [1:0]   out_idx;
    logic [W-1:0] out_data;
`ifdef PERF_CNT_SATURATE_EN
    logic         out_sat;
    logic         o4_sat;
`endif

    // Narrow instance used for the wrap/saturate check.
    logic         e4_valid = 1'b0;
    logic [N-1:0] e4_vec = '0;
    logic         c4_valid = 1'b0;
    logic [1:0]   c4_op = 2'd0;
    logic         r4_ready = 1'b0;
    logic         c4_ready, o4_valid, o4_last, o4_frozen, o4_busy;
    logic [1:0]   o4_idx;
    logic [3:0]   o4_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perf_counter_ctrl #(.NUM_EVENTS(N), .CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .event_valid(event_valid), .event_vec(event_vec),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .out_last(out_last),
`ifdef PERF_CNT_SATURATE_EN
        .out_sat(out_sat),
`endif
        .frozen(frozen), .busy(busy)
    );

    perf_counter_ctrl #(.NUM_EVENTS(N), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .event_valid(e4_valid), .event_vec(e4_vec),
        .cmd_valid(c4_valid), .cmd_op(c4_op), .cmd_ready(c4_ready),
        .out_valid(o4_valid), .out_ready(r4_ready), .out_idx(o4_idx),
        .out_data(o4_data), .out_last(o4_last),
`ifdef PERF_CNT_SATURATE_EN
        .out_sat(o4_sat),
`endif
        .frozen(o4_frozen), .busy(o4_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: live counts, freeze flag, and a queue of beats still to be streamed.
    typedef struct packed {
        logic [1:0]   idx;
        logic [W-1:0] data;
        logic         last;
        logic         sat;
    } beat_t;

    beat_t        mq[$];
    logic [W-1:0] mcnt[N];
    bit           msat[N];
    bit           mfrozen = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) begin
            mcnt[i] = '0;
            msat[i] = 1'b0;
        end
    end

    always @(posedge clk or posedge rst) begin
        bit streaming;
        bit acc;
        if (rst) begin
            mq.delete();
            mfrozen = 1'b0;
            for (int i = 0; i < N; i++) begin
                mcnt[i] = '0;
                msat[i] = 1'b0;
            end
        end else begin
            streaming = (mq.size() != 0);
            acc       = cmd_valid && !streaming;
            if (streaming && out_ready) void'(mq.pop_front());
            if (event_valid && !mfrozen) begin
                for (int i = 0; i < N; i++) begin
                    if (event_vec[i]) begin
`ifdef PERF_CNT_SATURATE_EN
                        if (mcnt[i] == {W{1'b1}}) msat[i] = 1'b1;
                        else mcnt[i] = mcnt[i] + 1;
`else
                        mcnt[i] = mcnt[i] + 1;
`endif
                    end
                end
            end
            if (acc) begin
                case (cmd_op)
                    2'd0: for (int i = 0; i < N; i++) begin
                        mcnt[i] = '0;
                        msat[i] = 1'b0;
                    end
                    2'd1: for (int i = 0; i < N; i++)
                        mq.push_back('{idx: 2'(i), data: mcnt[i], last: (i == N - 1), sat: msat[i]});
                    2'd2: mfrozen = 1'b1;
                    default: mfrozen = 1'b0;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        ev = (mq.size() != 0);
        check("out_valid", out_valid, ev);
        check("busy", busy, ev);
        check("cmd_ready", cmd_ready, !ev);
        check("frozen", frozen, mfrozen);
        if (ev) begin
            check("out_idx", out_idx, mq[0].idx);
            check("out_data", out_data, mq[0].data);
            check("out_last", out_last, mq[0].last);
`ifdef PERF_CNT_SATURATE_EN
            check("out_sat", out_sat, mq[0].sat);
`endif
        end
    end

    task automatic send_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Issue DUMP, drain the stream and compare each beat with literals.
    // stall: out_ready pattern 1,0,0,1,0,0...; clr: hold CLEAR during the stream.
    task automatic run_dump(input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3,
                            input bit stall, input bit clr);
        logic [W-1:0] exp[N];
        int  cyc;
        int  got;
        bit  done;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (clr) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'd0;
        end
        got = 0; done = 1'b0; cyc = 0;
        while (!done && cyc < 100) begin
            if (out_valid) begin
                out_ready = stall ? (cyc % 3 == 0) : 1'b1;
                check("dump_data", out_data, exp[out_idx]);
                check("dump_idx", out_idx, got);
                check("dump_last", out_last, got == N - 1);
                if (out_ready) begin
                    got++;
                    if (got == N) done = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("dump_beats", got, N);
        if (clr) begin
            check("clear_ready_after_stream", cmd_ready, 1'b1);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values.
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frozen", frozen, 1'b0);
        check("rst_out_idx", out_idx, 2'd0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 10 events on counters 0 and 1.
        event_valid = 1'b1;
        event_vec   = 4'b0011;
        repeat (10) @(negedge clk);
        event_valid = 1'b0;
        check("model_cnt0_after_10", mcnt[0], 10);
        run_dump(10, 10, 0, 0, 1'b0, 1'b0);

        // Freeze / unfreeze same-cycle rules.
        send_cmd(2'd0);
        event_valid = 1'b1;
        event_vec   = 4'b1111;
        send_cmd(2'd2);                 // event on FREEZE edge is counted
        repeat (5) @(negedge clk);      // frozen: ignored
        send_cmd(2'd3);                 // event on UNFREEZE edge is not counted
        @(negedge clk);                 // counted
        event_valid = 1'b0;
        check("model_cnt3_after_freeze", mcnt[3], 2);
        run_dump(2, 2, 2, 2, 1'b0, 1'b0);

        // Stalled stream while events keep firing; CLEAR held off during STREAM.
        event_valid = 1'b1;
        event_vec   = 4'b0101;
        run_dump(3, 2, 3, 2, 1'b1, 1'b1);
        event_valid = 1'b0;
        run_dump(0, 0, 0, 0, 1'b0, 1'b0);

        // CLEAR beats a simultaneous event at count 7.
        event_valid = 1'b1;
        event_vec   = 4'b1111;
        repeat (7) @(negedge clk);
        check("model_pre_clear", mcnt[0], 7);
        send_cmd(2'd0);
        event_valid = 1'b0;
        run_dump(0, 0, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream at out_idx == 2.
        event_valid = 1'b1;
        event_vec   = 4'b1111;
        repeat (3) @(negedge clk);
        event_valid = 1'b0;
        send_cmd(2'd1);
        out_ready = 1'b1;
        n = 0;
        while (out_idx != 2'd2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_idx2", out_idx, 2'd2);
        check("abort_idx2_data", out_data, 3);
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_out_idx", out_idx, 2'd0);
        check("abort_out_data", out_data, 0);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run_dump(0, 0, 0, 0, 1'b0, 1'b0);

        // Narrow counters: 17 events on counter 0.
        e4_valid = 1'b1;
        e4_vec   = 4'b0001;
        repeat (17) @(negedge clk);
        e4_valid = 1'b0;
        c4_valid = 1'b1;
        c4_op    = 2'd1;
        @(negedge clk);
        c4_valid = 1'b0;
        r4_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            check("w4_valid", o4_valid, 1'b1);
            check("w4_idx", o4_idx, k);
            check("w4_last", o4_last, k == N - 1);
`ifdef PERF_CNT_SATURATE_EN
            check("w4_data", o4_data, (k == 0) ? 15 : 0);
            check("w4_sat", o4_sat, k == 0);
`else
            check("w4_data", o4_data, (k == 0) ? 1 : 0);
`endif
            @(negedge clk);
        end
        r4_ready = 1'b0;
        check("w4_done", o4_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
